// File: rtl/pattern_pkg.sv
// Shared constants for the serial pattern detector: default pattern, LED FSM encoding
// and the rate of the shared hold tick.
package pattern_pkg;

    localparam int         PATTERN_LEN_DEF = 7;
    localparam logic [6:0] PATTERN_DEF     = 7'b1011001;
    localparam int         TICK_HZ         = 1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } led_state_t;

endpackage

// File: rtl/tick_pulse_stretcher.sv
// Stretches a single-cycle trigger into a hold that lasts HOLD_TICKS tick periods;
// a trigger while holding restarts the hold.
module tick_pulse_stretcher
    import pattern_pkg::*;
#(
    parameter int HOLD_TICKS = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic tick,
    output logic active
);

    localparam int HW = $clog2(HOLD_TICKS + 1);

    led_state_t    state;
    led_state_t    stateNext;
    logic [HW-1:0] holdCnt;
    logic [HW-1:0] holdNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            holdCnt <= '0;
        end else begin
            state   <= stateNext;
            holdCnt <= holdNext;
        end
    end

    // A trigger always reloads, so a coincident tick is simply not counted.
    always_comb begin
        stateNext = state;
        holdNext  = holdCnt;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    stateNext = ST_HOLD;
                    holdNext  = HW'(HOLD_TICKS);
                end
            end
            ST_HOLD: begin
                if (trig) begin
                    holdNext = HW'(HOLD_TICKS);
                end else if (tick) begin
                    if (holdCnt == HW'(1)) begin
                        stateNext = ST_IDLE;
                        holdNext  = '0;
                    end else begin
                        holdNext = holdCnt - HW'(1);
                    end
                end
            end
            default: begin
                stateNext = ST_IDLE;
                holdNext  = '0;
            end
        endcase
    end

    assign active = (state == ST_HOLD);

endmodule

// File: rtl/seq_pattern_detector.sv
// Watches the accepted serial bit stream, flags when the newest PATTERN_LEN bits equal
// PATTERN, counts matches and drives a tick-timed LED hold.
module seq_pattern_detector
    import pattern_pkg::*;
#(
    parameter int                     PATTERN_LEN = PATTERN_LEN_DEF,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(PATTERN_DEF),
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     HOLD_TICKS  = 500,
    parameter int                     CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    input  logic                   clr,
    output logic [PATTERN_LEN-1:0] history,
    output logic                   pattern_hit,
    output logic                   hit_led,
    output logic [CNT_W-1:0]       hit_count
);

    localparam int FW = $clog2(PATTERN_LEN + 1);

    logic [FW-1:0]          fill;
    logic [FW-1:0]          nextFill;
    logic [PATTERN_LEN-1:0] nextHist;
    logic                   match;

    // bit_valid is a one-cycle strobe with no back-pressure: bit_in is consumed on the
    // rising edge where bit_valid is high, and clr on the same edge discards it.
    always_comb begin
        nextHist = {history[PATTERN_LEN-2:0], bit_in};
        nextFill = (fill == FW'(PATTERN_LEN)) ? fill : fill + FW'(1);
        match    = bit_valid && !clr && (nextHist == PATTERN) && (nextFill == FW'(PATTERN_LEN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history     <= '0;
            fill        <= '0;
            pattern_hit <= 1'b0;
            hit_count   <= '0;
        end else if (clr) begin
            history     <= '0;
            fill        <= '0;
            pattern_hit <= 1'b0;
            hit_count   <= '0;
        end else begin
            pattern_hit <= match;
            if (bit_valid) begin
                history <= nextHist;
                fill    <= (match && !OVERLAP) ? '0 : nextFill;
            end
            if (match && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

    tick_pulse_stretcher #(
        .HOLD_TICKS(HOLD_TICKS)
    ) u_stretch (
        .clk   (clk),
        .rst   (rst),
        .trig  (match),
        .tick  (tick),
        .active(hit_led)
    );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: six parameter variants share one stimulus stream and
// are checked every cycle against a bit-queue model plus directed literal expectations.
module tb_seq_pattern_detector;

    localparam int         N        = 6;
    localparam logic [6:0] PAT      = 7'b1011001;
    localparam logic [6:0] PATS [N] = '{7'b1011001, 7'b0000001, 7'b1010101, 7'b1010101, 7'b1011001, 7'b1011001};
    localparam bit         OVLS [N] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam int         HOLDS[N] = '{500, 500, 500, 500, 3, 500};
    localparam int         CWS  [N] = '{8, 8, 8, 8, 8, 2};

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic tick      = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_in    = 1'b0;
    logic clr       = 1'b0;

    logic [6:0] hist [N];
    logic       hitv [N];
    logic       ledv [N];
    logic [7:0] cnt  [N];

    int n_checks = 0;
    int n_pass   = 0;

    // clock / reset
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        logic [CWS[g]-1:0] c;
        seq_pattern_detector #(
            .PATTERN_LEN(7),
            .PATTERN    (PATS[g]),
            .OVERLAP    (OVLS[g]),
            .HOLD_TICKS (HOLDS[g]),
            .CNT_W      (CWS[g])
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .bit_valid  (bit_valid),
            .bit_in     (bit_in),
            .clr        (clr),
            .history    (hist[g]),
            .pattern_hit(hitv[g]),
            .hit_led    (ledv[g]),
            .hit_count  (c)
        );
        assign cnt[g] = 8'(c);
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // scoreboard model: bits accepted since the last refill point, ticks seen since last hit
    int m_hist [N];
    int m_bits [N];
    int m_cnt  [N];
    int m_ticks[N];
    bit m_hit  [N];
    bit m_act  [N];
    bit h;

    initial begin
        for (int k = 0; k < N; k++) begin
            m_hist[k] = 0; m_bits[k] = 0; m_cnt[k] = 0; m_ticks[k] = 0; m_hit[k] = 0; m_act[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_hist[k] = 0; m_bits[k] = 0; m_cnt[k] = 0; m_ticks[k] = 0; m_hit[k] = 0; m_act[k] = 0;
            end else begin
                h = 1'b0;
                if (clr) begin
                    m_hist[k] = 0; m_bits[k] = 0; m_cnt[k] = 0;
                end else if (bit_valid) begin
                    m_hist[k] = ((m_hist[k] * 2) + int'(bit_in)) % 128;
                    m_bits[k] = m_bits[k] + 1;
                    if (m_bits[k] >= 7 && m_hist[k] == int'(PATS[k])) begin
                        h = 1'b1;
                        if (!OVLS[k]) m_bits[k] = 0;
                        if (m_cnt[k] < (1 << CWS[k]) - 1) m_cnt[k] = m_cnt[k] + 1;
                    end
                end
                if (h) begin
                    m_act[k] = 1'b1; m_ticks[k] = 0;
                end else if (m_act[k] && tick) begin
                    m_ticks[k] = m_ticks[k] + 1;
                    if (m_ticks[k] >= HOLDS[k]) m_act[k] = 1'b0;
                end
                m_hit[k] = h;
            end
        end
        #2;
        for (int k = 0; k < N; k++) begin
            check($sformatf("u%0d history", k), int'(hist[k]), m_hist[k]);
            check($sformatf("u%0d pattern_hit", k), int'(hitv[k]), int'(m_hit[k]));
            check($sformatf("u%0d hit_led", k), int'(ledv[k]), int'(m_act[k]));
            check($sformatf("u%0d hit_count", k), int'(cnt[k]), m_cnt[k]);
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send_bit(bits[n-1-i]);
            if (i != n - 1) idle(gap);
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic tick10();
        idle(9);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        idle(3);
        check("reset history", int'(hist[0]), 0);
        check("reset pattern_hit", int'(hitv[0]), 0);
        check("reset hit_led", int'(ledv[0]), 0);
        check("reset hit_count", int'(cnt[0]), 0);
        rst = 1'b0;
        idle(2);

        // default pattern with a 2-clk gap between strobes
        send_seq(16'(PAT), 7, 2);
        check("dflt hit", int'(hitv[0]), 1);
        check("dflt history", int'(hist[0]), 7'b1011001);
        check("dflt count", int'(cnt[0]), 1);
        check("dflt led", int'(ledv[0]), 1);
        idle(1);
        check("dflt hit one cycle", int'(hitv[0]), 0);

        // fill gate against an all-zero history
        do_clr();
        send_bit(1'b1);
        check("fill gate no hit", int'(hitv[1]), 0);
        send_seq(16'b0000001, 7, 1);
        check("0000001 hit", int'(hitv[1]), 1);
        check("0000001 count", int'(cnt[1]), 1);

        // overlapping vs non-overlapping
        do_clr();
        send_seq(16'b101010101, 9, 1);
        check("ovl1 count", int'(cnt[2]), 2);
        check("ovl1 hit bit9", int'(hitv[2]), 1);
        check("ovl0 count", int'(cnt[3]), 1);
        check("ovl0 no hit bit9", int'(hitv[3]), 0);
        check("ovl0 history", int'(hist[3]), 7'b1010101);

        // LED hold on the HOLD_TICKS=3 instance
        do_clr();
        repeat (3) tick10();
        check("hold idle", int'(ledv[4]), 0);
        send_seq(16'(PAT), 7, 1);
        check("hold start", int'(ledv[4]), 1);
        repeat (2) tick10();
        check("hold after 2 ticks", int'(ledv[4]), 1);
        tick10();
        check("hold end 3rd tick", int'(ledv[4]), 0);

        send_seq(16'(PAT), 7, 1);
        tick10();
        check("retrig before", int'(ledv[4]), 1);
        send_seq(16'(PAT), 7, 1);
        repeat (2) tick10();
        check("retrig 2 ticks", int'(ledv[4]), 1);
        tick10();
        check("retrig end", int'(ledv[4]), 0);

        send_seq(16'(PAT), 7, 1);
        tick10();
        send_seq(16'b101100, 6, 1);
        idle(1);
        bit_valid = 1'b1; bit_in = 1'b1; tick = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0; bit_in = 1'b0; tick = 1'b0;
        check("coinc hit", int'(hitv[4]), 1);
        repeat (2) tick10();
        check("coinc reload", int'(ledv[4]), 1);
        tick10();
        check("coinc end", int'(ledv[4]), 0);

        // saturating 2-bit counter
        do_clr();
        for (int i = 1; i <= 5; i++) begin
            send_seq(16'(PAT), 7, 1);
            check($sformatf("sat count %0d", i), int'(cnt[5]), (i < 3) ? i : 3);
        end
        send_seq(16'b101100, 6, 1);
        @(negedge clk);
        clr = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        clr = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        check("clr+valid count", int'(cnt[5]), 0);
        check("clr+valid history", int'(hist[5]), 0);
        check("clr+valid no hit", int'(hitv[5]), 0);

        // asynchronous reset during a hold
        send_seq(16'(PAT), 7, 1);
        check("pre-rst led", int'(ledv[0]), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst led", int'(ledv[0]), 0);
        check("async rst count", int'(cnt[0]), 0);
        check("async rst history", int'(hist[0]), 0);
        idle(2);
        rst = 1'b0;
        send_bit(1'b1);
        check("post-rst fill gate", int'(hitv[1]), 0);
        idle(1);
        send_seq(16'b011001, 6, 1);
        check("post-rst full pattern", int'(hitv[0]), 1);

        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Downstream consumer of the button-driven serial bit stream: it sees the same din/en pair that feeds the shift register.
- Keeps its own PATTERN_LEN-bit history and flags when the last PATTERN_LEN accepted bits equal a programmable pattern.
- Counts matches and stretches each match into a human-visible LED hold timed by the shared 1 kHz tick.
- Sits beside the shift register in the top level. Its outputs drive a spare LED and a 7-seg/count display path.

Parameters:
- PATTERN_LEN, 7, number of bits compared.
- PATTERN, 7'b1011001, target sequence. MSB is the oldest bit, LSB is the newest.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history must refill completely after a match.
- HOLD_TICKS, 500, LED hold length in tick periods. Must be at least 1.
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- tick  in  1  1-cycle strobe from tickGen (1 kHz)
- bit_valid  in  1  1-cycle strobe: accept bit_in this cycle (driven by the en of the top level)
- bit_in  in  1  serial data bit (driven by the din of the top level)
- clr  in  1  synchronous clear of hit_count, history and fill; the LED FSM is not affected
- history  out  PATTERN_LEN  accepted bits, newest in bit 0
- pattern_hit  out  1  1-cycle match pulse
- hit_led  out  1  high while the hold is active
- hit_count  out  CNT_W  saturating match count

Behaviour:
- Reset: history=0, fill=0, pattern_hit=0, hit_led=0, hit_count=0, FSM=IDLE, hold_cnt=0.
- Accept: on a clk edge with bit_valid=1, history <= {history[PATTERN_LEN-2:0], bit_in}. When bit_valid=0, history holds.
- Fill gate: fill counts accepted bits and saturates at PATTERN_LEN. The match check uses the post-shift fill, so no match is possible before PATTERN_LEN bits have arrived since reset or clr. This blocks false matches against reset zeros.
- Match: the combinational value next_hist==PATTERN && next_fill==PATTERN_LEN, qualified by bit_valid.
  - pattern_hit is registered: high for exactly the cycle after the accepting edge.
  - Latency is 1 clk from bit_valid to pattern_hit.
- OVERLAP=0: on a match, fill is reset to 0; history still holds the matched bits. OVERLAP=1: fill stays saturated.
- hit_count: increments on each match, registered in the same edge as pattern_hit. It saturates at 2^CNT_W-1 and never wraps.
- clr with bit_valid in the same cycle: clr wins. History and fill go to 0, the bit is dropped and no match is produced.
- LED FSM has two states, IDLE and HOLD.
  - IDLE: a match loads hold_cnt=HOLD_TICKS and moves to HOLD.
  - HOLD: each tick decrements hold_cnt. A tick with hold_cnt==1 moves to IDLE.
  - A match while in HOLD reloads hold_cnt=HOLD_TICKS and stays in HOLD (retrigger).
  - Match and tick in the same cycle: the reload wins and the tick is ignored.
- hit_led is registered and equals (state==HOLD), so it rises 1 clk after pattern_hit-source edge, i.e. concurrent with pattern_hit.
- The hold lasts between HOLD_TICKS-1 and HOLD_TICKS full tick periods, because the tick phase is asynchronous to the match.
- Reset mid-hold: hit_led drops immediately (asynchronous), and the FSM returns to IDLE.

Decomposition:
- Shared package (pattern_pkg): PATTERN_LEN default, default PATTERN, FSM state encoding constants (ST_IDLE=1'b0, ST_HOLD=1'b1), tick rate constant.
- One natural sub-module: tick_pulse_stretcher. It contains the LED FSM and hold counter, with inputs trig and tick and output active, parameterised by HOLD_TICKS. The top level of the block holds the history, fill, match logic and counter.

Test Plan:
- Defaults; after reset feed the bits 1,0,1,1,0,0,1 (oldest first) with a bit_valid gap of ≥2 clk -> pattern_hit pulses once, 1 clk after the 7th strobe; history=7'b1011001; hit_count=1; hit_led=1.
- PATTERN=7'b0000001; immediately after reset feed a single 1 -> no pattern_hit, because fill=1. Then feed 0,0,0,0,0,0,1 -> exactly one hit, on the 7th bit of that group.
- PATTERN=7'b1010101; feed 1,0,1,0,1,0,1,0,1 -> OVERLAP=1 gives hits after bits 7 and 9 (hit_count=2); OVERLAP=0 gives one hit after bit 7 (hit_count=1).
- HOLD_TICKS=3, 1 tick every 10 clk; one hit -> hit_led falls on the 3rd tick after the hit. A second hit between the 1st and 2nd tick extends the hold to the 3rd tick after the second hit. A match and a tick in the same cycle leave hold_cnt=3.
- CNT_W=2; produce 5 hits -> hit_count reads 1,2,3,3,3. clr asserted together with bit_valid -> count=0, history=0, no pulse.
- Assert rst during HOLD, asynchronously between edges -> hit_led, hit_count and history go to 0 at once. After release, a full 7-bit pattern is needed before the next hit.
